modbus_uart_rx: RTL

//  Asynchronous serial receiver feeding the MODBUS slave endpoint's RX interface (ready/rxerr/din).

---
 rtl/modbus_uart_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/modbus_uart_rx.sv
// Asynchronous serial receiver (1 start, 8 data LSB first, optional parity, 1 stop) that
// feeds the MODBUS slave endpoint with one ready or rxerr strobe per character.
module modbus_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned PARITY       = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       ready,
   output logic       rxerr,
   output logic       busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e state_q, state_d;

   logic          sync1_q;
   logic          rxs;
   logic          rxs_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_q, bit_d;
   logic          par_q, par_d;
   logic          perr_q, perr_d;
   logic [7:0]    data_q, data_d;
   logic          ready_q, ready_d;
   logic          rxerr_q, rxerr_d;
   logic          sample;

   // Synchroniser and edge-detect history all reset to the idle (high) line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         rxs        <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync1_q    <= rx;
         rxs        <= sync1_q;
         rxs_prev_q <= rxs;
      end
   end

   assign sample = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      par_d   = par_q;
      perr_d  = perr_q;
      data_d  = data_q;
      ready_d = 1'b0;
      rxerr_d = 1'b0;

      if (state_q != StIdle) begin
         cnt_d = sample ? CNT_FULL : cnt_q - CW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (rxs_prev_q && !rxs) begin
               cnt_d   = CNT_HALF;
               state_d = StStart;
            end
         end
         StStart: begin
            if (sample) begin
               if (rxs) begin
                  state_d = StIdle;
               end else begin
                  bit_d   = 3'd0;
                  par_d   = 1'b0;
                  perr_d  = 1'b0;
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (sample) begin
               shift_d = {rxs, shift_q[7:1]};
               par_d   = par_q ^ rxs;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = (PARITY != 0) ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (sample) begin
               // par_q ^ rxs is 1 when the total count of ones is odd.
               perr_d  = (PARITY == 2) ? (par_q ^ rxs) : ~(par_q ^ rxs);
               state_d = StStop;
            end
         end
         StStop: begin
            if (sample) begin
               if (rxs && !perr_q) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
               end else begin
                  rxerr_d = 1'b1;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         shift_q <= 8'h00;
         bit_q   <= 3'd0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
         data_q  <= 8'h00;
         ready_q <= 1'b0;
         rxerr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         rxerr_q <= rxerr_d;
      end
   end

   assign data  = data_q;
   assign ready = ready_q;
   assign rxerr = rxerr_q;
   assign busy  = (state_q != StIdle);

endmodule
